data_mem_ctrl: RTL

- Multi-cycle data-memory responder for the single-issue RISC-V datapath.
- Consumes the decoder's MemRead/MemWrite, the ALU address and the rs2 store data.
- Holds a byte-addressed little-endian RAM and performs the access after LATENCY wait cycles.
- Stalls the pipeline until it returns ReadData or commits the store.

---
 rtl/data_mem_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/data_mem_ctrl.sv
// Multi-cycle byte-addressed little-endian data memory with pipeline stall/done handshake.
// Optional `MEM_MISALIGN_CHECK_EN adds a Misaligned output and suppresses misaligned accesses.
module data_mem_ctrl #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2,
  parameter int XLEN    = 64
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic [XLEN-1:0] Address,
  input  logic [XLEN-1:0] WriteData,
  input  logic [1:0]      Size,
  input  logic            Unsigned,
  output logic [XLEN-1:0] ReadData,
  output logic            Stall,
  output logic            Done
`ifdef MEM_MISALIGN_CHECK_EN
  ,
  output logic            Misaligned
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int NB = XLEN / 8;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic            wr_q, wr_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            mis_q, mis_d;

  logic [7:0]      mem [DEPTH];

  logic            req;
  logic            access;
  logic            stall_c;
  logic [AW-1:0]   eff_addr;
  logic [XLEN-1:0] eff_wdata;
  logic [1:0]      eff_size;
  logic            eff_uns;
  logic            eff_wr;
  logic            mis;
  logic            mem_we;
  logic            sign;
  logic [XLEN-1:0] rd_raw;
  logic [XLEN-1:0] size_mask;
  logic [XLEN-1:0] ext;
  logic [AW-1:0]   lane_addr [NB];
  logic [NB-1:0]   lane_en;
  logic            addr_unused;

  assign req         = MemRead | MemWrite;
  assign addr_unused = ^Address[XLEN-1:AW];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    size_d    = size_q;
    uns_d     = uns_q;
    wr_d      = wr_q;
    eff_addr  = addr_q;
    eff_wdata = wdata_q;
    eff_size  = size_q;
    eff_uns   = uns_q;
    eff_wr    = wr_q;
    access    = 1'b0;
    stall_c   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          stall_c = 1'b1;
          addr_d  = Address[AW-1:0];
          wdata_d = WriteData;
          size_d  = Size;
          uns_d   = Unsigned;
          wr_d    = MemWrite;
          if (LATENCY == 0) begin
            // Zero latency: access straight off the request inputs at the capture edge.
            access    = 1'b1;
            state_d   = S_RESP;
            eff_addr  = Address[AW-1:0];
            eff_wdata = WriteData;
            eff_size  = Size;
            eff_uns   = Unsigned;
            eff_wr    = MemWrite;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CW'(LATENCY - 1);
          end
        end
      end
      S_WAIT: begin
        stall_c = 1'b1;
        if (cnt_q == '0) begin
          access  = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Byte lanes wrap modulo DEPTH; lanes beyond the access size are disabled.
  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      assign lane_addr[gi]          = eff_addr + AW'(gi);
      assign lane_en[gi]            = (gi < (1 << eff_size));
      assign size_mask[8*gi +: 8]   = {8{lane_en[gi]}};
      assign rd_raw[8*gi +: 8]      = lane_en[gi] ? mem[lane_addr[gi]] : 8'h00;
    end
  endgenerate

  always_comb begin
    unique case (eff_size)
      2'd0:    sign = rd_raw[7];
      2'd1:    sign = rd_raw[15];
      2'd2:    sign = rd_raw[31];
      default: sign = rd_raw[XLEN-1];
    endcase
    ext = (rd_raw & size_mask) | ({XLEN{sign & ~eff_uns}} & ~size_mask);
  end

`ifdef MEM_MISALIGN_CHECK_EN
  always_comb begin
    unique case (eff_size)
      2'd0:    mis = 1'b0;
      2'd1:    mis = eff_addr[0];
      2'd2:    mis = |eff_addr[1:0];
      default: mis = |eff_addr[2:0];
    endcase
  end
  assign Misaligned = mis_q;
`else
  assign mis = 1'b0;
`endif

  always_comb begin
    rdata_d = rdata_q;
    if (access && !eff_wr) begin
      rdata_d = mis ? '0 : ext;
    end
    mis_d = access & mis;
  end

  // Gating with reset_n keeps a store from landing on the edge where reset is held.
  assign mem_we = access & eff_wr & ~mis & reset_n;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (lane_en[i]) begin
          mem[lane_addr[i]] <= eff_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
    end
  end

  assign ReadData = rdata_q;
  assign Stall    = reset_n & stall_c;
  assign Done     = (state_q == S_RESP);

endmodule
